// File: rtl/rvvi_ack_pkg.sv
// Shared types and constants for the RVVI acknowledgement generator.
package rvvi_ack_pkg;

  typedef enum logic {
    STATE_IDLE,
    STATE_SEND
  } state_t;

  // Ack frame length in 32-bit beats and the width of the beat counter.
  localparam int ACK_BEATS = 7;
  localparam int BEAT_W    = $clog2(ACK_BEATS);

  // Beat indices; each beat carries one field group of the ack frame.
  localparam logic [BEAT_W-1:0] BEAT_DST_HI       = 3'd0;
  localparam logic [BEAT_W-1:0] BEAT_DST_LO_SRC   = 3'd1;
  localparam logic [BEAT_W-1:0] BEAT_SRC_LO       = 3'd2;
  localparam logic [BEAT_W-1:0] BEAT_ETHTYPE      = 3'd3;
  localparam logic [BEAT_W-1:0] BEAT_TAG          = 3'd4;
  localparam logic [BEAT_W-1:0] BEAT_MINSTRET_HI  = 3'd5;
  localparam logic [BEAT_W-1:0] BEAT_MINSTRET_LO  = 3'd6;
  localparam logic [BEAT_W-1:0] ACK_LAST_BEAT     = BEAT_MINSTRET_LO;

  // Queue entries hold the tag zero-extended to a fixed field, so any
  // window size up to 2^15 fits the same struct and the same beat 4 layout.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    logic [63:0]          minstret;
    logic [47:0]          dstmac;
  } ack_entry_t;

  localparam int ACK_ENTRY_W = $bits(ack_entry_t);

  // Data word for one beat of the ack frame built from a queue entry.
  function automatic logic [31:0] ack_beat(input logic [BEAT_W-1:0] beat,
                                           input ack_entry_t        e,
                                           input logic [47:0]       srcmac,
                                           input logic [15:0]       ethtype);
    logic [31:0] w;
    w = 32'h0;
    case (beat)
      BEAT_DST_HI:      w = e.dstmac[47:16];
      BEAT_DST_LO_SRC:  w = {e.dstmac[15:0], srcmac[47:32]};
      BEAT_SRC_LO:      w = srcmac[31:0];
      BEAT_ETHTYPE:     w = {ethtype, 16'h0};
      BEAT_TAG:         w = {16'h0, e.tag};
      BEAT_MINSTRET_HI: w = e.minstret[63:32];
      BEAT_MINSTRET_LO: w = e.minstret[31:0];
      default:          w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rvvi_ack_fifo.sv
// Pointer FIFO for pending acks: wrap-bit pointers, registered full/empty,
// plus a look-ahead port giving the entry that becomes head after a pop.
module rvvi_ack_fifo #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              next_valid,
  output logic [DATA_W-1:0] next_data,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt, count;
  logic [ADDR_W-1:0] rd_idx_p1;
  logic              push_ok, pop_ok;

  // Qualify requests with the registered flags; a push is refused while
  // full even if a pop happens in the same cycle.
  always_comb begin
    push_ok   = push & ~full;
    pop_ok    = pop & ~empty;
    wr_nxt    = wr_ptr + PTR_W'(push_ok);
    rd_nxt    = rd_ptr + PTR_W'(pop_ok);
    count     = wr_ptr - rd_ptr;
    rd_idx_p1 = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
  end

  assign rdata = mem[rd_ptr[ADDR_W-1:0]];

  // Head after a pop: the second stored entry, or the entry being pushed
  // right now when only one is stored (bypass, since it is not yet in mem).
  always_comb begin
    next_valid = (count > PTR_W'(1)) | push_ok;
    next_data  = (count > PTR_W'(1)) ? mem[rd_idx_p1] : wdata;
  end

  // Pointers and flags; flags are computed from the next pointers so they
  // are valid in the cycle right after the update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[ADDR_W] != rd_nxt[ADDR_W]) &&
                (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

  // Storage write.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/rvvi_ack_gen.sv
// Host-side RVVI-over-Ethernet responder: classifies incoming frames
// against a tag window and streams one 7-beat ack per accepted frame.
module rvvi_ack_gen
  import rvvi_ack_pkg::*;
#(
  parameter int Entries = 3,
  parameter int CNTW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RxValid,
  input  logic [Entries:0]  RxTag,
  input  logic [63:0]       RxMinstret,
  input  logic [47:0]       RxSrcMac,
  input  logic [47:0]       LocalMac,
  input  logic [15:0]       EthType,
  input  logic              TxReady,
  output logic              TxValid,
  output logic [31:0]       TxData,
  output logic              TxLast,
  output logic              Full,
  output logic              Empty,
  output logic [Entries:0]  ExpectedTag,
  output logic [CNTW-1:0]   OooCount,
  output logic [CNTW-1:0]   DupCount,
  output logic [CNTW-1:0]   DropCount
);

  localparam int TW  = Entries + 1;
  localparam int WIN = 1 << Entries;

  logic [WIN-1:0]    bitmap;
  logic [TW-1:0]     diff;
  logic              accept, drop, bm, in_order, ooo, dup, skip;
  ack_entry_t        push_entry, head, next_head;
  logic              next_valid, pop;
  state_t            state;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;

  // Classify the presented frame against the expected tag and the window.
  always_comb begin
    accept   = RxValid & ~Full;
    drop     = RxValid & Full;
    diff     = RxTag - ExpectedTag;
    bm       = bitmap[RxTag[Entries-1:0]];
    in_order = accept & (diff == '0) & ~bm;
    ooo      = accept & (diff != '0) & ~diff[Entries] & ~bm;
    dup      = accept & ~in_order & ~ooo;
    skip     = ~in_order & bitmap[ExpectedTag[Entries-1:0]];
  end

  // Expected-tag advance and received bitmap. An out-of-order set never hits
  // the index being cleared by a skip, because its diff is non-zero.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExpectedTag <= '0;
      bitmap      <= '0;
    end else begin
      if (in_order | skip) ExpectedTag <= ExpectedTag + TW'(1);
      if (skip) bitmap[ExpectedTag[Entries-1:0]] <= 1'b0;
      if (ooo)  bitmap[RxTag[Entries-1:0]]       <= 1'b1;
    end
  end

  // Statistics counters, wrapping naturally at 2^CNTW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OooCount  <= '0;
      DupCount  <= '0;
      DropCount <= '0;
    end else begin
      if (ooo)  OooCount  <= OooCount  + CNTW'(1);
      if (dup)  DupCount  <= DupCount  + CNTW'(1);
      if (drop) DropCount <= DropCount + CNTW'(1);
    end
  end

  assign push_entry = '{tag: TAG_MAX_W'(RxTag), minstret: RxMinstret, dstmac: RxSrcMac};

  rvvi_ack_fifo #(
    .ADDR_W (Entries),
    .DATA_W (ACK_ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .pop        (pop),
    .wdata      (push_entry),
    .rdata      (head),
    .next_valid (next_valid),
    .next_data  (next_head),
    .full       (Full),
    .empty      (Empty)
  );

  // The head entry leaves the queue when its final beat is accepted.
  always_comb begin
    pop      = (state == STATE_SEND) & TxReady & (beat_cnt == ACK_LAST_BEAT);
    beat_nxt = beat_cnt + BEAT_W'(1);
  end

  // TX FSM with registered beat outputs; data for the following beat is
  // loaded on each accepted beat, so outputs hold while TxReady is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= STATE_IDLE;
      beat_cnt <= '0;
      TxValid  <= 1'b0;
      TxData   <= '0;
      TxLast   <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (!Empty) begin
            state    <= STATE_SEND;
            beat_cnt <= '0;
            TxValid  <= 1'b1;
            TxData   <= ack_beat(BEAT_DST_HI, head, LocalMac, EthType);
            TxLast   <= 1'b0;
          end
        end
        STATE_SEND: begin
          if (TxReady) begin
            if (beat_cnt == ACK_LAST_BEAT) begin
              beat_cnt <= '0;
              TxLast   <= 1'b0;
              if (next_valid) begin
                TxData <= ack_beat(BEAT_DST_HI, next_head, LocalMac, EthType);
              end else begin
                state   <= STATE_IDLE;
                TxValid <= 1'b0;
                TxData  <= '0;
              end
            end else begin
              beat_cnt <= beat_nxt;
              TxData   <= ack_beat(beat_nxt, head, LocalMac, EthType);
              TxLast   <= (beat_nxt == ACK_LAST_BEAT);
            end
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rvvi_ack_gen.md
Name: rvvi_ack_gen

Overview:
- Host-side responder for the RVVI-over-Ethernet trace link.
- Accepts decoded incoming RVVI instruction frames (sequence tag, minstret, sender MAC).
- Tracks the next expected tag with a received-bitmap window, classifying each frame as in-order, out-of-order or duplicate (replay).
- Queues one acknowledgement per accepted frame and serialises each ack as a 7-beat 32-bit Ethernet TX stream back to the DUT-side active list.

Parameters:
- Entries, 3, log2 of ack queue depth and of the tag window; tag width is Entries+1.
- CNTW, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- RxValid  in  1  one-cycle strobe, a decoded RVVI frame is presented
- RxTag  in  Entries+1  frame sequence tag
- RxMinstret  in  64  frame minstret
- RxSrcMac  in  48  frame source MAC; becomes the ack destination
- LocalMac  in  48  host MAC; the ack source, quasi-static
- EthType  in  16  ack ethertype, quasi-static
- TxReady  in  1  TX sink accepts the current beat
- TxValid  out  1  beat valid
- TxData  out  32  beat data
- TxLast  out  1  final beat of the ack frame
- Full  out  1  ack queue full (registered)
- Empty  out  1  ack queue empty (registered)
- ExpectedTag  out  Entries+1  next in-order tag
- OooCount  out  CNTW  out-of-order frames received
- DupCount  out  CNTW  duplicate frames received
- DropCount  out  CNTW  frames dropped because the queue was full

Behaviour:
- Reset (async, active-high): TxValid=0, TxData=0, TxLast=0, Full=0, Empty=1, ExpectedTag=0, all counters=0, bitmap cleared, queue pointers=0, FSM=IDLE.
- Accept: on RxValid & ~Full, push {RxTag, RxMinstret, RxSrcMac}. The queue has 2^Entries entries and uses Entries+1-bit pointers (MSB wrap bit).
  - Full = pointers equal except MSB. Empty = pointers equal.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - Full is registered, so a push is refused while Full=1 even if a pop occurs that cycle.
- Drop: on RxValid & Full, DropCount += 1. No push. No change to ExpectedTag, bitmap, OooCount or DupCount.
- Classification (accepted frames only): diff = RxTag - ExpectedTag mod 2^(Entries+1); bm = bitmap[RxTag[Entries-1:0]].
  - diff==0 & ~bm: in-order. ExpectedTag += 1 at the next edge.
  - 0<diff<2^Entries & ~bm: out-of-order. Set bm; OooCount += 1.
  - diff>=2^Entries, or bm set: duplicate. DupCount += 1.
  - Every accepted frame is acked, including duplicates.
- Skip-advance: in any cycle with no in-order accept, if bitmap[ExpectedTag[Entries-1:0]] is set, clear that bit and increment ExpectedTag. Advance is one tag per cycle.
  - A same-cycle out-of-order set touches a different index, so both updates occur.
- Counters wrap modulo 2^CNTW.
- FSM (2 states):
  - IDLE: TxValid=0. If ~Empty, go to SEND with BeatCnt=0.
  - SEND: TxValid=1. BeatCnt advances on TxReady.
  - On beat 6 accepted: pop the queue. If the queue is still non-empty after the pop, stay in SEND with BeatCnt=0 (back-to-back frames, no idle cycle). Otherwise go to IDLE.
  - TxData and TxLast are registered and held stable while TxValid & ~TxReady.
- Beat map (head entry; D=dst=RxSrcMac, S=LocalMac):
  - b0 D[47:16]
  - b1 {D[15:0],S[47:32]}
  - b2 S[31:0]
  - b3 {EthType,16'h0}
  - b4 {zero-pad,Tag}
  - b5 Minstret[63:32]
  - b6 Minstret[31:0], TxLast=1
- Acks leave in arrival order, not tag order.
- Reset mid-frame: all outputs clear immediately. The partial frame is abandoned and is not resent.

Decomposition:
- Package rvvi_ack_pkg: state enum {STATE_IDLE, STATE_SEND}; constants ACK_BEATS=7, ACK_LAST_BEAT=6, the beat field offsets, and the ack entry struct {tag, minstret, dstmac}.
- One sub-module, rvvi_ack_fifo: the parameterised pointer FIFO with registered Full/Empty and async reset.
- Classification, bitmap, counters and the TX FSM stay in the top module.

Test Plan:
- In-order (Entries=3), TxReady=1: tags 0,1,2 with minstret 10,11,12. Expect 3 frames (21 beats); b4 = 0,1,2; b6 = 10,11,12; TxLast on beats 6/13/20; ExpectedTag=3; OooCount=DupCount=0.
- Out-of-order: tags 0,2,3,1. Expect OooCount=2; ExpectedTag goes 1 → 2 on the edge after tag 1, then 3, then 4 over two further cycles; bitmap=0 afterwards; acks emitted with b4 = 0,2,3,1.
- Duplicate: after ExpectedTag=4, send tag 1 (diff=13). Expect DupCount=1, ExpectedTag stays 4, ack with b4=1 emitted. Then send tag 6 twice: OooCount+1, then DupCount+1.
- Backpressure: drop TxReady for 5 cycles while b2 is presented. TxValid=1 and TxData=S[31:0] held stable; the frame completes with 7 beats total after release.
- Full/drop: TxReady=0, send 9 frames tags 0..8. Expect Full=1 after the 8th; 9th dropped with DropCount=1 and ExpectedTag=8; release TxReady; 8 acks drain; Empty=1.
- Async reset asserted between clock edges during b3. Expect TxValid, Full and counters cleared without a clock edge, ExpectedTag=0, and no further beats after release.
